// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state codes, MEM/WB payload and bubble value.
package mem_access_stage_pkg;

  // Two-bit state encoding; the spare codes fall back to IDLE in the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } state_t;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  rd;
    logic        reg_write;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '{value: '0, rd: '0, reg_write: 1'b0};

  // Memory is word addressed; the byte offset never reaches the port.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: load, bubble insert (clears write enable, holds rd/value), sync reset.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  // Register update; load takes priority over bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= MEMWB_BUBBLE;
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.reg_write <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data-memory port, owns MEM/WB,
// stalls upstream while an access is outstanding, aborts on timeout.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned ld/st raise mem_err instead of accessing memory.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exmem_valid,
  input  logic [31:0] exmem_result,
  input  logic [31:0] exmem_wdata,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regWrite,
  input  logic        exmem_memRead,
  input  logic        exmem_memWrite,
  input  logic        exmem_memToReg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] valueToWB,
  output logic [4:0]  rd_MEMWB,
  output logic        regWrite_MEMWB,
  output logic        mem_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_mem, misalign, timeout;
  logic             issue, done, abort, trap;
  logic             wb_load, wb_bubble;
  memwb_t           wb_d, wb_q;

  assign is_mem  = exmem_valid & (exmem_memRead | exmem_memWrite);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (exmem_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Next-state, stall and MEM/WB control; ack beats timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    trap      = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    wb_d      = '{value: exmem_result, rd: exmem_rd, reg_write: exmem_regWrite};
    case (state_q)
      ST_IDLE: begin
        if (is_mem && misalign) begin
          trap      = 1'b1;
          wb_bubble = 1'b1;
        end else if (is_mem) begin
          stall     = 1'b1;
          issue     = 1'b1;
          wb_bubble = 1'b1;
          state_d   = ST_BUSY;
        end else if (exmem_valid) begin
          wb_load = 1'b1;
        end else begin
          wb_bubble = 1'b1;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          done       = 1'b1;
          wb_load    = 1'b1;
          wb_d.value = exmem_memToReg ? dmem_rdata : exmem_result;
          state_d    = ST_IDLE;
        end else if (timeout) begin
          // Stall is released on the abort cycle so the dead instruction leaves EX/MEM.
          abort     = 1'b1;
          wb_bubble = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: begin
        wb_bubble = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Timeout counter: cleared on issue, counts BUSY cycles, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= '0;
    end else if (state_q == ST_BUSY && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Data-memory port drivers, held stable from issue until ack or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= exmem_memWrite;
      dmem_addr  <= word_addr(exmem_result);
      dmem_wdata <= exmem_wdata;
    end else if (done || abort) begin
      dmem_req <= 1'b0;
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (reset)              mem_err <= 1'b0;
    else if (abort || trap) mem_err <= 1'b1;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign valueToWB      = wb_q.value;
  assign rd_MEMWB       = wb_q.rd;
  assign regWrite_MEMWB = wb_q.reg_write;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mem_access_stage;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_valid, exmem_regWrite, exmem_memRead, exmem_memWrite, exmem_memToReg;
  logic [31:0] exmem_result, exmem_wdata;
  logic [4:0]  exmem_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall;
  logic [31:0] valueToWB;
  logic [4:0]  rd_MEMWB;
  logic        regWrite_MEMWB, mem_err;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .exmem_valid(exmem_valid), .exmem_result(exmem_result), .exmem_wdata(exmem_wdata),
    .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
    .exmem_memWrite(exmem_memWrite), .exmem_memToReg(exmem_memToReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .valueToWB(valueToWB), .rd_MEMWB(rd_MEMWB),
    .regWrite_MEMWB(regWrite_MEMWB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Transaction-level model: one outstanding access with its age in BUSY cycles.
  bit          m_pend = 0, m_we = 0, m_err = 0, m_rw = 0, run = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_val = '0;
  logic [4:0]  m_rd = '0;
  int          m_age = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0; m_we = 0; m_err = 0; m_rw = 0;
      m_addr = '0; m_wdata = '0; m_val = '0; m_rd = '0; m_age = 0;
    end else if (!m_pend) begin
      if (exmem_valid && (exmem_memRead || exmem_memWrite)) begin
        m_rw = 0;
        if (misal(exmem_result)) m_err = 1;
        else begin
          m_pend = 1; m_age = 0; m_we = exmem_memWrite;
          m_addr = exmem_result & ~32'd3; m_wdata = exmem_wdata;
        end
      end else if (exmem_valid) begin
        m_val = exmem_result; m_rd = exmem_rd; m_rw = exmem_regWrite;
      end else m_rw = 0;
    end else begin
      if (dmem_ack) begin
        m_pend = 0;
        m_val  = exmem_memToReg ? dmem_rdata : exmem_result;
        m_rd   = exmem_rd; m_rw = exmem_regWrite;
      end else if (m_age == int'(TO) - 1) begin
        m_pend = 0; m_err = 1; m_rw = 0;
      end else begin
        m_age++; m_rw = 0;
      end
    end
    run = 1;
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (run) begin
      chk("req", dmem_req, m_pend);
      if (m_pend) begin
        chk("we", dmem_we, m_we);
        chk("addr", dmem_addr, m_addr);
        chk("wdata", dmem_wdata, m_wdata);
      end
      chk("valueToWB", valueToWB, m_val);
      chk("rd_MEMWB", rd_MEMWB, m_rd);
      chk("regWrite_MEMWB", regWrite_MEMWB, m_rw);
      chk("mem_err", mem_err, m_err);
      if (!reset) begin
        if (m_pend)
          chk("stall", stall, !(dmem_ack || m_age == int'(TO) - 1));
        else
          chk("stall", stall, exmem_valid && (exmem_memRead || exmem_memWrite) && !misal(exmem_result));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic m2r);
    exmem_valid = v; exmem_result = res; exmem_wdata = wd; exmem_rd = rd;
    exmem_regWrite = rw; exmem_memRead = mr; exmem_memWrite = mw; exmem_memToReg = m2r;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    idle();
    tick(); tick();
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_value", valueToWB, 32'h0);
    chk("rst_err", mem_err, 1'b0);
    reset = 1'b0;
    tick();

    // ALU pass-through
    drive(1'b1, 32'h1234, '0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("alu_stall", stall, 1'b0);
    tick(); idle();
    #1 chk("alu_value", valueToWB, 32'h1234);
    chk("alu_rd", rd_MEMWB, 32'd5);
    chk("alu_rw", regWrite_MEMWB, 1'b1);
    tick();
    chk("alu_bubble_rw", regWrite_MEMWB, 1'b0);

    // Load, ack 3 cycles after req
    n = 0;
    drive(1'b1, 32'h40, '0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 if (stall) n++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall) n++;
      chk("ld_req", dmem_req, 1'b1);
      chk("ld_addr", dmem_addr, 32'h40);
    end
    tick(); dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_stall", stall, 1'b0);
    tick(); dmem_ack = 1'b0; idle();
    #1 chk("ld_stall_cycles", n, 32'd4);
    chk("ld_value", valueToWB, 32'hDEADBEEF);
    chk("ld_rd", rd_MEMWB, 32'd7);
    chk("ld_rw", regWrite_MEMWB, 1'b1);
    chk("ld_req_drop", dmem_req, 1'b0);
    tick();

    // Store, ack on first BUSY cycle
    drive(1'b1, 32'h80, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); dmem_ack = 1'b1;
    #1 chk("st_we", dmem_we, 1'b1);
    chk("st_addr", dmem_addr, 32'h80);
    chk("st_wdata", dmem_wdata, 32'h55);
    chk("st_stall", stall, 1'b0);
    tick(); dmem_ack = 1'b0; idle();
    #1 chk("st_req_drop", dmem_req, 1'b0);
    chk("st_rw", regWrite_MEMWB, 1'b0);
    tick();

    // Ack on the last allowed cycle wins over timeout
    drive(1'b1, 32'h44, '0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    repeat (TO - 1) tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick(); dmem_ack = 1'b0; idle();
    #1 chk("edge_value", valueToWB, 32'hCAFEF00D);
    chk("edge_rw", regWrite_MEMWB, 1'b1);
    chk("edge_err", mem_err, 1'b0);
    tick();

    // memRead & memWrite both set: store; regWrite set with memToReg=0 writes the address
    drive(1'b1, 32'h100, 32'hA5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("both_we", dmem_we, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h77;
    tick(); dmem_ack = 1'b0; idle();
    #1 chk("both_value", valueToWB, 32'h100);
    chk("both_rw", regWrite_MEMWB, 1'b1);

    // Stray ack while idle is ignored
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;
    #1 chk("stray_req", dmem_req, 1'b0);
    chk("stray_rw", regWrite_MEMWB, 1'b0);
    tick();

    // Misaligned load at 0x41
    drive(1'b1, 32'h41, '0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("mis_stall", stall, 1'b0);
    tick(); idle();
    #1 chk("mis_req", dmem_req, 1'b0);
    chk("mis_err", mem_err, 1'b1);
    chk("mis_rw", regWrite_MEMWB, 1'b0);
`else
    tick();
    chk("mis_req", dmem_req, 1'b1);
    chk("mis_addr", dmem_addr, 32'h40);
    dmem_ack = 1'b1; dmem_rdata = 32'h11112222;
    tick(); dmem_ack = 1'b0; idle();
    #1 chk("mis_value", valueToWB, 32'h11112222);
    chk("mis_err", mem_err, 1'b0);
`endif
    tick();

    // Timeout
    drive(1'b1, 32'h200, '0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    repeat (TO - 1) tick();
    chk("to_last_req", dmem_req, 1'b1);
    chk("to_last_stall", stall, 1'b0);
    tick(); idle();
    #1 chk("to_req", dmem_req, 1'b0);
    chk("to_err", mem_err, 1'b1);
    chk("to_rw", regWrite_MEMWB, 1'b0);
    chk("to_stall", stall, 1'b0);
    tick();
    chk("to_err_sticky", mem_err, 1'b1);

    // Reset during BUSY, ack arrives afterwards
    drive(1'b1, 32'h300, '0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    tick(); reset = 1'b0; idle();
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD;
    #1 chk("rb_req", dmem_req, 1'b0);
    chk("rb_we", dmem_we, 1'b0);
    chk("rb_addr", dmem_addr, 32'h0);
    chk("rb_stall", stall, 1'b0);
    chk("rb_err", mem_err, 1'b0);
    chk("rb_value", valueToWB, 32'h0);
    chk("rb_rd", rd_MEMWB, 32'h0);
    tick(); dmem_ack = 1'b0;
    #1 chk("rb_rw", regWrite_MEMWB, 1'b0);
    chk("rb_value2", valueToWB, 32'h0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
